// File: rtl/leb128_stream_dec.sv
// leb128_stream_dec: byte-serial LEB128 decoder on a valid/ready stream.
// Accumulates 7-bit groups into a W-bit value, emits value, byte length and
// a malformed flag. Signed/unsigned decoding is selected per value.
// Optional build macro: LEB128_STRICT_EN (checks the dropped high bits of a
// maximum-length value; without it those bits are silently discarded).
module leb128_stream_dec #(
  parameter int unsigned W    = 64,
  parameter int unsigned MAXB = (W + 6) / 7,
  parameter int unsigned LW   = $clog2(MAXB + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sgn,
  output logic [W-1:0]  o,
  output logic [LW-1:0] len,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int unsigned SW = $clog2(7 * MAXB);

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    SKIP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  acc, acc_d;
  logic [SW-1:0] sh, sh_d;
  logic [LW-1:0] cnt, cnt_d;
  logic          sgn_q, sgn_d;
  logic [W-1:0]  o_d;
  logic [LW-1:0] len_d;
  logic          err_d;
  logic          ov_d;

  logic          take;
  logic          sgn_eff;
  logic          last_full;
  logic          strict_bad;
  logic [LW-1:0] cnt_inc;
  logic [W-1:0]  pay_sh;
  logic [W-1:0]  ext_mask;
  logic [W-1:0]  result;

  // Handshake and per-byte helpers
  assign in_ready  = (state != HOLD);
  assign take      = in_valid & in_ready;
  assign cnt_inc   = cnt + LW'(1);
  assign last_full = (cnt_inc == LW'(MAXB));
  // sgn is only meaningful on the first byte; later bytes use the latched copy
  assign sgn_eff   = (cnt == '0) ? sgn : sgn_q;
  // Payload placed at bit 7k; anything landing at or above W falls off the top
  assign pay_sh    = W'({{W{1'b0}}, in_data[6:0]} << sh);

  // Sign-extension mask: ones from bit 7*len upward (empty once 7*len >= W)
  always_comb begin
    ext_mask = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (i >= 7 * int'(cnt_inc)) ext_mask[i] = 1'b1;
    end
  end

  // Final value for a terminating byte
  assign result = acc | pay_sh | ((sgn_eff && in_data[6]) ? ext_mask : '0);

`ifdef LEB128_STRICT_EN
  // Index of the first payload bit of the last legal byte that lands at/above W
  localparam int unsigned TOPB = W - 7 * (MAXB - 1);

  // Dropped bits must be zero (unsigned) or copies of bit W-1 (signed)
  always_comb begin
    strict_bad = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (j >= int'(TOPB)) begin
        strict_bad = strict_bad |
                     (sgn_eff ? (in_data[j] != in_data[TOPB-1]) : in_data[j]);
      end
    end
  end
`else
  assign strict_bad = 1'b0;
`endif

  // Next-state and next-register values
  always_comb begin
    state_d = state;
    acc_d   = acc;
    sh_d    = sh;
    cnt_d   = cnt;
    sgn_d   = sgn_q;
    o_d     = o;
    len_d   = len;
    err_d   = err;
    ov_d    = out_valid;

    case (state)
      ACC: begin
        if (take) begin
          sgn_d = sgn_eff;
          acc_d = acc | pay_sh;
          cnt_d = cnt_inc;
          sh_d  = sh + SW'(7);
          if (in_data[7]) begin
            if (last_full) begin
              state_d = SKIP;
              err_d   = 1'b1;
            end
          end else begin
            state_d = HOLD;
            o_d     = result;
            len_d   = cnt_inc;
            err_d   = last_full & strict_bad;
            ov_d    = 1'b1;
          end
        end
      end

      SKIP: begin
        if (take && !in_data[7]) begin
          state_d = HOLD;
          o_d     = '0;
          len_d   = LW'(MAXB);
          err_d   = 1'b1;
          ov_d    = 1'b1;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          ov_d    = 1'b0;
          acc_d   = '0;
          sh_d    = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      sh        <= '0;
      cnt       <= '0;
      sgn_q     <= 1'b0;
      o         <= '0;
      len       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      sh        <= sh_d;
      cnt       <= cnt_d;
      sgn_q     <= sgn_d;
      o         <= o_d;
      len       <= len_d;
      err       <= err_d;
      out_valid <= ov_d;
    end
  end

endmodule

// File: tb/tb_leb128_stream_dec.sv
// tb_leb128_stream_dec: directed vectors for leb128_stream_dec at W=64 and W=32.
module tb_leb128_stream_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W=64 instance signals
  logic [7:0]  d64 = '0;
  logic        v64 = 1'b0;
  logic        r64;
  logic        s64 = 1'b0;
  logic [63:0] o64;
  logic [3:0]  l64;
  logic        e64;
  logic        ov64;
  logic        ordy64 = 1'b0;

  // W=32 instance signals
  logic [7:0]  d32 = '0;
  logic        v32 = 1'b0;
  logic        r32;
  logic        s32 = 1'b0;
  logic [31:0] o32;
  logic [2:0]  l32;
  logic        e32;
  logic        ov32;
  logic        ordy32 = 1'b0;

  int total = 0;
  int bad   = 0;

  leb128_stream_dec #(.W(64)) u64 (
    .clk(clk), .rst(rst), .in_data(d64), .in_valid(v64), .in_ready(r64),
    .sgn(s64), .o(o64), .len(l64), .err(e64), .out_valid(ov64),
    .out_ready(ordy64)
  );

  leb128_stream_dec #(.W(32)) u32 (
    .clk(clk), .rst(rst), .in_data(d32), .in_valid(v32), .in_ready(r32),
    .sgn(s32), .o(o32), .len(l32), .err(e32), .out_valid(ov32),
    .out_ready(ordy32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one byte and wait until the decoder takes it
  task automatic push(input bit sel, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (sel) begin d32 = b; v32 = 1'b1; end
    else     begin d64 = b; v64 = 1'b1; end
    while (!(sel ? r32 : r64) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    v32 = 1'b0;
    v64 = 1'b0;
  endtask

  // Wait for a result, compare it, then hand it off
  task automatic pop(input bit sel, input string tag, input logic [63:0] eo,
                     input int el, input bit ee);
    int n = 0;
    while (!(sel ? ov32 : ov64) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 64'(sel ? ov32 : ov64), 64'(1));
    check({tag, ".o"},     sel ? {32'd0, o32} : o64, eo);
    check({tag, ".len"},   sel ? 64'(l32) : 64'(l64), 64'(el));
    check({tag, ".err"},   64'(sel ? e32 : e64), 64'(ee));
    @(negedge clk);
    if (sel) ordy32 = 1'b1; else ordy64 = 1'b1;
    @(posedge clk);
    #1;
    ordy32 = 1'b0;
    ordy64 = 1'b0;
    check({tag, ".drop"}, 64'(sel ? ov32 : ov64), 64'(0));
  endtask

  initial begin
    logic [63:0] held;
    bit strict;
`ifdef LEB128_STRICT_EN
    strict = 1'b1;
`else
    strict = 1'b0;
`endif

    // Reset values
    #23;
    check("rst.o",     o64, 64'd0);
    check("rst.len",   64'(l64), 64'd0);
    check("rst.err",   64'(e64), 64'd0);
    check("rst.valid", 64'(ov64), 64'd0);
    check("rst.ready", 64'(r64), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned 3-byte value, output one cycle after the last byte
    s64 = 1'b0;
    push(0, 8'hE5);
    push(0, 8'h8E);
    check("t1.early", 64'(ov64), 64'd0);
    push(0, 8'h26);
    check("t1.lat", 64'(ov64), 64'd1);
    pop(0, "t1", 64'd624485, 3, 1'b0);

    // Signed all-ones, 10 bytes
    s64 = 1'b1;
    for (int i = 0; i < 9; i++) push(0, 8'hFF);
    push(0, 8'h01);
    pop(0, "t2", 64'hFFFF_FFFF_FFFF_FFFF, 10, strict);

    // Signed two-byte negative: -128
    push(0, 8'h80);
    push(0, 8'h7F);
    pop(0, "neg128", 64'hFFFF_FFFF_FFFF_FF80, 2, 1'b0);

    // W=32 signed single bytes
    s32 = 1'b1;
    push(1, 8'h7F);
    pop(1, "t3a", 64'h0000_0000_FFFF_FFFF, 1, 1'b0);
    push(1, 8'h3F);
    pop(1, "t3b", 64'd63, 1, 1'b0);

    // Overlong value goes through SKIP
    s64 = 1'b0;
    for (int i = 0; i < 10; i++) push(0, 8'h80);
    check("t4.skip_ready", 64'(r64), 64'd1);
    check("t4.skip_valid", 64'(ov64), 64'd0);
    push(0, 8'h00);
    pop(0, "t4", 64'd0, 10, 1'b1);

    // Backpressure: result held while the next byte waits
    push(0, 8'hAC);
    push(0, 8'h02);
    @(negedge clk);
    held = o64;
    d64 = 8'h7F;
    v64 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5.hold_ready", 64'(r64), 64'd0);
      check("t5.hold_o", o64, held);
      check("t5.hold_valid", 64'(ov64), 64'd1);
    end
    v64 = 1'b0;
    pop(0, "t5a", 64'd300, 2, 1'b0);
    push(0, 8'h7F);
    pop(0, "t5b", 64'd127, 1, 1'b0);

    // Reset mid-value discards the partial value
    push(0, 8'hE5);
    push(0, 8'h8E);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5r.valid", 64'(ov64), 64'd0);
    check("t5r.ready", 64'(r64), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5r.quiet", 64'(ov64), 64'd0);
    end
    push(0, 8'h26);
    pop(0, "t5r", 64'd38, 1, 1'b0);

    // Unsigned with dropped high bits set on the last legal byte
    s64 = 1'b0;
    for (int i = 0; i < 9; i++) push(0, 8'hFF);
    push(0, 8'h7F);
    pop(0, "t6", 64'hFFFF_FFFF_FFFF_FFFF, 10, strict);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
